// File: rtl/sensor_init_seq.sv
// Table-driven camera sensor register initialisation sequencer.
// Walks a per-profile command ROM, emitting register writes and timed delays.
module sensor_init_seq #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned VAL_W    = 8,
  parameter int unsigned IDX_W    = 8,
  parameter int unsigned PROF_W   = 1,
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [PROF_W-1:0]           profile,
  output logic [PROF_W+IDX_W-1:0]     tbl_addr,
  input  logic [2+ADDR_W+VAL_W-1:0]   tbl_data,
  output logic [ADDR_W+VAL_W-1:0]     data,
  output logic                        valid,
  input  logic                        ready,
  output logic                        busy,
  output logic                        done,
  output logic                        error
);

  localparam int unsigned WORD_W = ADDR_W + VAL_W;
  localparam int unsigned CNT_W  = WORD_W + $clog2(TICK_DIV + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_DELAY = 2'b01;
  localparam logic [1:0] OP_END   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_WRITE,
    S_DELAY,
    S_DONE
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [PROF_W-1:0]  profile_q;
  logic [CNT_W-1:0]   cnt;

  logic [1:0]         op_c;
  logic [WORD_W-1:0]  word_c;
  logic [CNT_W-1:0]   prod_c;
  logic [CNT_W-1:0]   delay_load_c;
  logic               advance_c;
  logic               last_c;

  // ROM word fields and delay length; a zero-length delay still costs one cycle
  assign op_c         = tbl_data[WORD_W+1:WORD_W];
  assign word_c       = tbl_data[WORD_W-1:0];
  assign prod_c       = CNT_W'(word_c) * CNT_W'(TICK_DIV);
  assign delay_load_c = (prod_c == '0) ? CNT_W'(1) : prod_c;

  // An entry completes on write acceptance or on the final delay cycle
  assign advance_c = ((state == S_WRITE) && ready) ||
                     ((state == S_DELAY) && (cnt == CNT_W'(1)));
  assign last_c    = (idx == LAST_IDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      profile_q <= '0;
      cnt       <= '0;
      tbl_addr  <= '0;
      data      <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else if (abort && (state != S_IDLE)) begin
      // Abort withdraws any pending word and wins over start/ready
      state <= S_IDLE;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            profile_q <= profile;
            idx       <= '0;
            tbl_addr  <= {profile, IDX_W'(0)};
            done      <= 1'b0;
            error     <= 1'b0;
            busy      <= 1'b1;
            state     <= S_FETCH;
          end
        end

        S_FETCH: state <= S_DECODE;

        S_DECODE: begin
          case (op_c)
            OP_WRITE: begin
              data  <= word_c;
              valid <= 1'b1;
              state <= S_WRITE;
            end
            OP_DELAY: begin
              cnt   <= delay_load_c;
              state <= S_DELAY;
            end
            OP_END: begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end
            default: begin
              done  <= 1'b1;
              error <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end
          endcase
        end

        S_WRITE: begin
          if (ready) valid <= 1'b0;
        end

        S_DELAY: cnt <= cnt - CNT_W'(1);

        default: state <= S_IDLE;
      endcase

      // Step to the next entry; running off the table end is an error
      if (advance_c) begin
        if (last_c) begin
          done  <= 1'b1;
          error <= 1'b1;
          busy  <= 1'b0;
          state <= S_DONE;
        end else begin
          idx      <= idx + IDX_W'(1);
          tbl_addr <= {profile_q, idx + IDX_W'(1)};
          state    <= S_FETCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_sensor_init_seq.sv
// Directed bench for sensor_init_seq with a small behavioural ROM.
// Cycle numbers in comments are posedges counted from the one that samples start.
module tb_sensor_init_seq;

  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned VAL_W    = 8;
  localparam int unsigned IDX_W    = 2;
  localparam int unsigned PROF_W   = 1;
  localparam int unsigned TICK_DIV = 4;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic                      start;
  logic                      abort;
  logic [PROF_W-1:0]         profile;
  logic [PROF_W+IDX_W-1:0]   tbl_addr;
  logic [2+ADDR_W+VAL_W-1:0] tbl_data;
  logic [ADDR_W+VAL_W-1:0]   data;
  logic                      valid;
  logic                      ready;
  logic                      busy;
  logic                      done;
  logic                      error;

  logic [17:0] rom [8];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) tbl_data <= rom[tbl_addr];

  sensor_init_seq #(
    .ADDR_W(ADDR_W), .VAL_W(VAL_W), .IDX_W(IDX_W),
    .PROF_W(PROF_W), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .profile(profile), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .data(data), .valid(valid), .ready(ready),
    .busy(busy), .done(done), .error(error)
  );

  function automatic logic [17:0] ent(input logic [1:0] op, input logic [15:0] v);
    return {op, v};
  endfunction

  task automatic test_reset();
    reset_n = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0; profile = '0;
    for (int i = 0; i < 8; i++) rom[i] = ent(2'b10, 16'h0000);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({tbl_addr, data, valid, busy, done, error} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got addr=%h data=%h v=%b b=%b d=%b e=%b want all 0",
               tbl_addr, data, valid, busy, done, error);
    end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk); @(negedge clk);
    n_checks++;
    if ({valid, busy, done, error} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_idle: got v=%b b=%b d=%b e=%b want 0000", valid, busy, done, error);
    end
  endtask

  task automatic test_basic();
    logic [9:0] exp_v    = 10'b0000100100;
    logic [9:0] exp_busy = 10'b0011111111;
    logic [9:0] exp_done = 10'b1100000000;
    rom[0] = ent(2'b00, 16'h1280);
    rom[1] = ent(2'b00, 16'h1101);
    rom[2] = ent(2'b10, 16'h0000);
    ready = 1'b1; profile = 1'b0; start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if ({valid, busy, done} !== {exp_v[i], exp_busy[i], exp_done[i]}) begin
        n_fail++;
        $display("FAIL basic_flags cyc%0d: got v/b/d=%b%b%b want %b%b%b",
                 i, valid, busy, done, exp_v[i], exp_busy[i], exp_done[i]);
      end
      if (exp_v[i]) begin
        n_checks++;
        if (data !== ((i == 2) ? 16'h1280 : 16'h1101)) begin
          n_fail++;
          $display("FAIL basic_data cyc%0d: got %h", i, data);
        end
      end
    end
    n_checks++;
    if (error !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_error: got %b want 0", error);
    end
  endtask

  task automatic test_backpressure();
    ready = 1'b0; profile = 1'b0; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 3; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (valid !== 1'b1 || data !== 16'h1280 || tbl_addr !== 3'b000) begin
        n_fail++;
        $display("FAIL bp_hold cyc%0d: got v=%b data=%h addr=%b want 1 1280 000",
                 i, valid, data, tbl_addr);
      end
    end
    ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b0 || tbl_addr !== 3'b001) begin
      n_fail++;
      $display("FAIL bp_accept: got v=%b addr=%b want 0 001", valid, tbl_addr);
    end
    for (int i = 9; i < 14; i++) begin
      @(negedge clk);
      if (i == 10) begin
        n_checks++;
        if (valid !== 1'b1 || data !== 16'h1101) begin
          n_fail++;
          $display("FAIL bp_second: got v=%b data=%h want 1 1101", valid, data);
        end
      end
      if (i == 13) begin
        n_checks++;
        if (done !== 1'b1 || error !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_done: got d=%b e=%b want 1 0", done, error);
        end
      end
    end
  endtask

  task automatic test_profile1();
    rom[4] = ent(2'b01, 16'h0003);
    rom[5] = ent(2'b00, 16'h3A04);
    rom[6] = ent(2'b10, 16'h0000);
    ready = 1'b1; profile = 1'b1; start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      profile = 1'b0;
      start = (i == 6);
      n_checks++;
      if (tbl_addr[2] !== 1'b1) begin
        n_fail++;
        $display("FAIL p1_msb cyc%0d: got addr=%b want msb 1", i, tbl_addr);
      end
      n_checks++;
      if (valid !== (i == 16)) begin
        n_fail++;
        $display("FAIL p1_valid cyc%0d: got %b want %b", i, valid, (i == 16));
      end
      if (i == 16) begin
        n_checks++;
        if (data !== 16'h3A04) begin
          n_fail++;
          $display("FAIL p1_data: got %h want 3a04", data);
        end
      end
      if (i == 13 || i == 14) begin
        n_checks++;
        if (tbl_addr !== ((i == 13) ? 3'b100 : 3'b101)) begin
          n_fail++;
          $display("FAIL p1_delay_len cyc%0d: got addr=%b", i, tbl_addr);
        end
      end
      n_checks++;
      if (done !== (i == 19) || busy !== (i < 19)) begin
        n_fail++;
        $display("FAIL p1_status cyc%0d: got d=%b b=%b want %b %b",
                 i, done, busy, (i == 19), (i < 19));
      end
    end
  endtask

  task automatic test_illegal();
    int nv = 0;
    rom[0] = ent(2'b00, 16'h55AA);
    rom[1] = ent(2'b11, 16'h6677);
    rom[2] = ent(2'b00, 16'h6677);
    rom[3] = ent(2'b10, 16'h0000);
    ready = 1'b1; profile = 1'b0; start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (valid) nv++;
      if (i == 2) begin
        n_checks++;
        if (data !== 16'h55AA) begin
          n_fail++;
          $display("FAIL ill_data: got %h want 55aa", data);
        end
      end
      if (i == 4 || i == 5 || i == 9) begin
        n_checks++;
        if ({done, error, busy} !== ((i == 4) ? 3'b001 : 3'b110)) begin
          n_fail++;
          $display("FAIL ill_status cyc%0d: got d/e/b=%b%b%b", i, done, error, busy);
        end
      end
    end
    n_checks++;
    if (nv != 1) begin
      n_fail++;
      $display("FAIL ill_words: got %0d valid cycles want 1", nv);
    end
  endtask

  task automatic test_overrun();
    logic [15:0] exp_d [4];
    int k = 0;
    exp_d = '{16'hA101, 16'hA202, 16'hA303, 16'hA404};
    for (int j = 0; j < 4; j++) rom[j] = ent(2'b00, exp_d[j]);
    ready = 1'b1; profile = 1'b0; start = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (valid !== (i == 2 || i == 5 || i == 8 || i == 11)) begin
        n_fail++;
        $display("FAIL ovr_valid cyc%0d: got %b", i, valid);
      end
      if (valid === 1'b1 && k < 4) begin
        n_checks++;
        if (data !== exp_d[k]) begin
          n_fail++;
          $display("FAIL ovr_data word%0d: got %h want %h", k, data, exp_d[k]);
        end
        k++;
      end
      if (i == 11 || i == 12) begin
        n_checks++;
        if ({done, error} !== ((i == 11) ? 2'b00 : 2'b11)) begin
          n_fail++;
          $display("FAIL ovr_status cyc%0d: got d=%b e=%b", i, done, error);
        end
      end
    end
    n_checks++;
    if (k != 4) begin
      n_fail++;
      $display("FAIL ovr_count: got %0d words want 4", k);
    end
    rom[0] = ent(2'b10, 16'h0000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({done, error, busy} !== 3'b001) begin
      n_fail++;
      $display("FAIL ovr_restart: got d/e/b=%b%b%b want 001", done, error, busy);
    end
    @(negedge clk); @(negedge clk);
    n_checks++;
    if ({done, error, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL ovr_restart_end: got d/e/b=%b%b%b want 100", done, error, busy);
    end
  endtask

  task automatic test_abort();
    rom[0] = ent(2'b00, 16'h1280);
    rom[1] = ent(2'b10, 16'h0000);
    ready = 1'b0; profile = 1'b0; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_checks++;
    if (valid !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre: got v=%b want 1", valid);
    end
    ready = 1'b1; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if ({valid, busy, done, error} !== 4'b0000 || tbl_addr !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_idle: got v/b/d/e=%b%b%b%b addr=%b want 0000 000",
               valid, busy, done, error, tbl_addr);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_stay cyc%0d: got v=%b b=%b want 0 0", i, valid, busy);
      end
    end
  endtask

  task automatic test_async_reset();
    ready = 1'b1; profile = 1'b1; start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre: got b=%b want 1", busy);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({tbl_addr, data, valid, busy, done, error} !== '0) begin
      n_fail++;
      $display("FAIL areset_outputs: got addr=%h data=%h v=%b b=%b d=%b e=%b want all 0",
               tbl_addr, data, valid, busy, done, error);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_profile1();
    test_illegal();
    test_overrun();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
